// File: rtl/ctrl_pkg.sv
// Shared pipeline-control definitions: opcodes, operand-source codes, scoreboard entry and decode helpers.
package ctrl_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_LOAD   = 4'h8;
    localparam logic [3:0] OP_STORE  = 4'h9;
    localparam logic [3:0] OP_BRANCH = 4'hC;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef struct packed {
        logic       valid;
        logic       is_load;
        logic [3:0] rd;
    } sb_entry_t;

    function automatic logic [3:0] ir_opcode(input logic [15:0] ir);
        return ir[15:12];
    endfunction

    function automatic logic [3:0] ir_rd(input logic [15:0] ir);
        return ir[11:8];
    endfunction

    function automatic logic [3:0] ir_rs1(input logic [15:0] ir);
        return ir[7:4];
    endfunction

    function automatic logic [3:0] ir_rs2(input logic [15:0] ir);
        return ir[3:0];
    endfunction

    function automatic logic writes_rd(input logic [3:0] op, input logic [3:0] rd);
        return (op != OP_NOP) && (op != OP_STORE) && (op != OP_BRANCH) && (rd != 4'd0);
    endfunction

    function automatic logic reads_rs1(input logic [3:0] op);
        return op != OP_NOP;
    endfunction

    function automatic logic reads_rs2(input logic [3:0] op);
        return (op != OP_NOP) && (op != OP_LOAD);
    endfunction

    // r0 is hardwired zero, so a zero source never matches.
    function automatic logic slot_hit(input sb_entry_t e, input logic [3:0] rs, input logic en);
        return en && (rs != 4'd0) && e.valid && (e.rd == rs);
    endfunction

endpackage

// File: rtl/hazard_sb.sv
// Three-slot in-flight destination scoreboard (EX -> MEM -> WB) with bubble insertion.
module hazard_sb
    import ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  sb_entry_t id_entry_i,
    input  logic      bubble_i,
    output sb_entry_t ex_o,
    output sb_entry_t mem_o,
    output sb_entry_t wb_o
);

    sb_entry_t ex_q, mem_q, wb_q;
    sb_entry_t ex_d;

    always_comb begin
        ex_d = id_entry_i;
        if (bubble_i) begin
            ex_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    assign ex_o  = ex_q;
    assign mem_o = mem_q;
    assign wb_o  = wb_q;

endmodule

// File: rtl/hazard_unit.sv
// Issue-side RAW hazard detection: stalls ID until producers leave WB.
// Optional HAZARD_FORWARDING_EN: operand forwarding with load-use-only stalls.
module hazard_unit
    import ctrl_pkg::*;
#(
    parameter int unsigned NREG = 16,
    parameter int unsigned IRW  = 16,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IRW-1:0]  i_ir_id,
    input  logic            i_id_valid,
    output logic            o_stall,
    output logic            o_bubble,
    output logic [1:0]      o_fwd_a,
    output logic [1:0]      o_fwd_b,
    output logic [CNTW-1:0] o_stall_cnt
);

    localparam int unsigned RAW = $clog2(NREG);

    sb_entry_t       sb_ex, sb_mem, sb_wb, id_entry;
    logic [3:0]      opcode, rd;
    logic [RAW-1:0]  rs1, rs2;
    logic            rs1_en, rs2_en;
    logic            ha_ex, ha_mem, ha_wb, hb_ex, hb_mem, hb_wb;
    logic            hazard_c;
    logic [1:0]      fwd_a_c, fwd_b_c;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
    logic            unused_is_load;

    // Decode ID, compare sources against every in-flight destination.
    always_comb begin
        opcode           = ir_opcode(i_ir_id[15:0]);
        rd               = ir_rd(i_ir_id[15:0]);
        rs1              = ir_rs1(i_ir_id[15:0]);
        rs2              = ir_rs2(i_ir_id[15:0]);
        rs1_en           = reads_rs1(opcode);
        rs2_en           = reads_rs2(opcode);
        id_entry.valid   = writes_rd(opcode, rd);
        id_entry.is_load = (opcode == OP_LOAD);
        id_entry.rd      = rd;
        ha_ex            = slot_hit(sb_ex,  rs1, rs1_en);
        ha_mem           = slot_hit(sb_mem, rs1, rs1_en);
        ha_wb            = slot_hit(sb_wb,  rs1, rs1_en);
        hb_ex            = slot_hit(sb_ex,  rs2, rs2_en);
        hb_mem           = slot_hit(sb_mem, rs2, rs2_en);
        hb_wb            = slot_hit(sb_wb,  rs2, rs2_en);
        hazard_c         = 1'b0;
        fwd_a_c          = FWD_RF;
        fwd_b_c          = FWD_RF;
`ifdef HAZARD_FORWARDING_EN
        hazard_c = (ha_ex || hb_ex) && sb_ex.is_load;
        fwd_a_c  = ha_ex ? FWD_EX : ha_mem ? FWD_MEM : ha_wb ? FWD_WB : FWD_RF;
        fwd_b_c  = hb_ex ? FWD_EX : hb_mem ? FWD_MEM : hb_wb ? FWD_WB : FWD_RF;
`else
        hazard_c = ha_ex || ha_mem || ha_wb || hb_ex || hb_mem || hb_wb;
`endif
    end

    assign unused_is_load = ^{sb_ex.is_load, sb_mem.is_load, sb_wb.is_load};

    // Outputs are forced to their idle values while reset is held.
    assign o_stall  = rst && i_id_valid && hazard_c;
    assign o_bubble = !rst || o_stall || !i_id_valid;
    assign o_fwd_a  = rst ? fwd_a_c : FWD_RF;
    assign o_fwd_b  = rst ? fwd_b_c : FWD_RF;

    hazard_sb u_sb (
        .clk        (clk),
        .rst        (rst),
        .id_entry_i (id_entry),
        .bubble_i   (o_bubble),
        .ex_o       (sb_ex),
        .mem_o      (sb_mem),
        .wb_o       (sb_wb)
    );

    // Saturating stall-cycle counter.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (o_stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with a scoreboard queue of expected outputs.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir_id;
    logic        id_valid;
    logic        stall, bubble;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] cnt;
    logic        stall2;
    logic [1:0]  cnt2;
    logic        unused_bubble2;
    logic [1:0]  unused_fa2, unused_fb2;

    int nerr = 0;
    int nchk = 0;
    logic [15:0] cnt_m  = 16'd0;
    logic [1:0]  cnt2_m = 2'd0;

    typedef struct {
        string       tag;
        logic        stall;
        logic        bubble;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
        logic [1:0]  fa;
        logic [1:0]  fb;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk         (clk),
        .rst         (rst),
        .i_ir_id     (ir_id),
        .i_id_valid  (id_valid),
        .o_stall     (stall),
        .o_bubble    (bubble),
        .o_fwd_a     (fwd_a),
        .o_fwd_b     (fwd_b),
        .o_stall_cnt (cnt)
    );

    hazard_unit #(.CNTW(2)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .i_ir_id     (ir_id),
        .i_id_valid  (id_valid),
        .o_stall     (stall2),
        .o_bubble    (unused_bubble2),
        .o_fwd_a     (unused_fa2),
        .o_fwd_b     (unused_fb2),
        .o_stall_cnt (cnt2)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        nchk++;
        assert (obs === exp_v) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One cycle: drive, queue expectation, sample at negedge, advance model, cross the edge.
    task automatic step(input string tag, input logic r, input logic v, input logic [15:0] ir,
                        input logic es, input logic [1:0] efa, input logic [1:0] efb);
        exp_t e;
        rst      = r;
        id_valid = v;
        ir_id    = ir;
        e.tag    = tag;
        e.stall  = es;
        e.bubble = !r || es || !v;
        e.cnt    = cnt_m;
        e.cnt2   = cnt2_m;
        e.fa     = efa;
        e.fb     = efb;
        sbq.push_back(e);
        @(negedge clk);
        e = sbq.pop_front();
        chk({e.tag, ":stall"},  16'(stall),  16'(e.stall));
        chk({e.tag, ":bubble"}, 16'(bubble), 16'(e.bubble));
        chk({e.tag, ":cnt"},    cnt,         e.cnt);
        chk({e.tag, ":stall2"}, 16'(stall2), 16'(e.stall));
        chk({e.tag, ":cnt2"},   16'(cnt2),   16'(e.cnt2));
        chk({e.tag, ":fwd_a"},  16'(fwd_a),  16'(e.fa));
        chk({e.tag, ":fwd_b"},  16'(fwd_b),  16'(e.fb));
        if (!r) begin
            cnt_m  = 16'd0;
            cnt2_m = 2'd0;
        end else if (e.stall) begin
            if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
            if (cnt2_m != 2'd3)    cnt2_m = cnt2_m + 2'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) step("idle", 1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 2'd0);
    endtask

    initial begin
        rst      = 1'b0;
        id_valid = 1'b1;
        ir_id    = 16'h1123;
        @(posedge clk);
        #1;

        step("rst_a", 1'b0, 1'b1, 16'h1123, 1'b0, 2'd0, 2'd0);
        step("rst_b", 1'b0, 1'b1, 16'h1123, 1'b0, 2'd0, 2'd0);
        chk("rst:ex_valid",  16'(dut.sb_ex.valid),  16'd0);
        chk("rst:mem_valid", 16'(dut.sb_mem.valid), 16'd0);
        chk("rst:wb_valid",  16'(dut.sb_wb.valid),  16'd0);
        step("idle0", 1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 2'd0);

        step("raw_prod", 1'b1, 1'b1, 16'h1123, 1'b0, 2'd0, 2'd0);
`ifdef HAZARD_FORWARDING_EN
        step("raw_fwd", 1'b1, 1'b1, 16'h2414, 1'b0, 2'd1, 2'd0);
`else
        step("raw_s1", 1'b1, 1'b1, 16'h2414, 1'b1, 2'd0, 2'd0);
        step("raw_s2", 1'b1, 1'b1, 16'h2414, 1'b1, 2'd0, 2'd0);
        step("raw_s3", 1'b1, 1'b1, 16'h2414, 1'b1, 2'd0, 2'd0);
        step("raw_go", 1'b1, 1'b1, 16'h2414, 1'b0, 2'd0, 2'd0);
`endif
        chk("raw:ex_valid", 16'(dut.sb_ex.valid), 16'd1);
        chk("raw:ex_rd",    16'(dut.sb_ex.rd),    16'd4);
        drain();

        step("r0_prod",  1'b1, 1'b1, 16'h1023, 1'b0, 2'd0, 2'd0);
        step("r0_cons",  1'b1, 1'b1, 16'h2400, 1'b0, 2'd0, 2'd0);
        step("ind_prod", 1'b1, 1'b1, 16'h1523, 1'b0, 2'd0, 2'd0);
        step("ind_cons", 1'b1, 1'b1, 16'h2467, 1'b0, 2'd0, 2'd0);
        drain();

`ifdef HAZARD_FORWARDING_EN
        for (int i = 0; i < 4; i++) begin
            step("lu_load",  1'b1, 1'b1, 16'h8310, 1'b0, 2'd0, 2'd0);
            step("lu_stall", 1'b1, 1'b1, 16'h2435, 1'b1, 2'd0, 2'd0);
            step("lu_mem",   1'b1, 1'b1, 16'h2435, 1'b0, 2'd2, 2'd0);
        end
        step("alu_prod", 1'b1, 1'b1, 16'h1312, 1'b0, 2'd0, 2'd0);
        step("alu_ex",   1'b1, 1'b1, 16'h2435, 1'b0, 2'd1, 2'd0);
        chk("sat:cnt2", 16'(cnt2), 16'd3);
        drain();
        step("mid_prod", 1'b1, 1'b1, 16'h8310, 1'b0, 2'd0, 2'd0);
        step("mid_rst",  1'b0, 1'b1, 16'h2435, 1'b0, 2'd0, 2'd0);
        step("mid_rel",  1'b1, 1'b1, 16'h2435, 1'b0, 2'd0, 2'd0);
`else
        step("sat_prod", 1'b1, 1'b1, 16'h1123, 1'b0, 2'd0, 2'd0);
        step("sat_s1",   1'b1, 1'b1, 16'h2414, 1'b1, 2'd0, 2'd0);
        step("sat_s2",   1'b1, 1'b1, 16'h2414, 1'b1, 2'd0, 2'd0);
        step("sat_s3",   1'b1, 1'b1, 16'h2414, 1'b1, 2'd0, 2'd0);
        step("sat_go",   1'b1, 1'b1, 16'h2414, 1'b0, 2'd0, 2'd0);
        chk("sat:cnt",  cnt,        16'd6);
        chk("sat:cnt2", 16'(cnt2), 16'd3);
        drain();
        step("mid_prod", 1'b1, 1'b1, 16'h1123, 1'b0, 2'd0, 2'd0);
        step("mid_s1",   1'b1, 1'b1, 16'h2414, 1'b1, 2'd0, 2'd0);
        step("mid_rst",  1'b0, 1'b1, 16'h2414, 1'b0, 2'd0, 2'd0);
        step("mid_rel",  1'b1, 1'b1, 16'h2414, 1'b0, 2'd0, 2'd0);
`endif
        chk("mid:ex_rd", 16'(dut.sb_ex.rd), 16'd4);
        step("end", 1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 2'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
